weight_glb_fill_ctrl: RTL

Upstream fill stage for the token engine's weight path. It accepts a 32-bit weight word stream from the DMA (valid/ready), packs it into the global buffer (GLB) starting at the layer's weight base address, and masks the byte lanes of a partial last word. It pulses a done flag so the token-engine sequencer can raise the weight-load state for the GLB-to-PE weight load controller.

---
 rtl/weight_glb_fill_ctrl_pkg.sv | 45 ++++
 rtl/weight_glb_fill_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/weight_glb_fill_ctrl_pkg.sv
// Shared types and lookups for the weight fill path: layer-type encodings,
// per-type weight counts and the partial-last-word lane mask.
package weight_glb_fill_ctrl_pkg;

    // Encodings shared with the GLB-to-PE weight load controller.
    typedef enum logic [1:0] {
        POINTWISE = 2'd0,
        DEPTHWISE = 2'd1,
        STANDARD  = 2'd2,
        LINEAR    = 2'd3
    } layer_type_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2
    } fill_state_e;

    localparam int unsigned WordCntW = 9;

    function automatic logic [10:0] weight_count(input logic [1:0] layer_type);
        case (layer_type)
            POINTWISE: weight_count = 11'd1024;
            DEPTHWISE: weight_count = 11'd90;
            STANDARD:  weight_count = 11'd900;
            LINEAR:    weight_count = 11'd1024;
            default:   weight_count = 11'd0;
        endcase
    endfunction

    // ceil(n/4); at most 256 so it fits the word counter.
    function automatic logic [WordCntW-1:0] word_count(input logic [10:0] n);
        word_count = WordCntW'((n + 11'd3) >> 2);
    endfunction

    function automatic logic [3:0] last_mask(input logic [1:0] rem);
        case (rem)
            2'd0:    last_mask = 4'b1111;
            2'd1:    last_mask = 4'b0001;
            2'd2:    last_mask = 4'b0011;
            default: last_mask = 4'b0111;
        endcase
    endfunction

endpackage

// File: rtl/weight_glb_fill_ctrl.sv
// Packs a 32-bit DMA weight stream into the GLB from the layer's base address,
// masking unused lanes of a partial last word, and pulses done at the end.
module weight_glb_fill_ctrl
    import weight_glb_fill_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  layer_type_i,
    input  logic [31:0] weight_GLB_base_addr_i,
    input  logic        dma_valid_i,
    input  logic [31:0] dma_data_i,
    output logic        dma_ready_o,
    output logic [3:0]  glb_WEB_o,
    output logic [31:0] glb_addr_o,
    output logic [31:0] glb_wdata_o,
    output logic        busy_o,
    output logic        weight_fill_done_o
);

    fill_state_e          state_q, state_d;
    logic [31:0]          base_q, base_d;
    logic [WordCntW-1:0]  last_idx_q, last_idx_d;
    logic [3:0]           mask_q, mask_d;
    logic [WordCntW-1:0]  word_cnt_q, word_cnt_d;
    logic [3:0]           web_q, web_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;

    logic [10:0]          n_weights;
    logic [WordCntW-1:0]  n_words;
    logic                 is_last;

    assign n_weights = weight_count(layer_type_i);
    assign n_words   = word_count(n_weights);
    assign is_last   = (word_cnt_q == last_idx_q);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        last_idx_d  = last_idx_q;
        mask_d      = mask_q;
        word_cnt_d  = word_cnt_q;
        web_d       = 4'b0000;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        dma_ready_o = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    base_d     = weight_GLB_base_addr_i & ~32'd3;
                    last_idx_d = n_words - WordCntW'(1);
                    mask_d     = last_mask(n_weights[1:0]);
                    word_cnt_d = '0;
                    state_d    = (n_words != '0) ? StFill : StDone;
                end
            end
            StFill: begin
                dma_ready_o = 1'b1;
                if (dma_valid_i) begin
                    web_d      = is_last ? mask_q : 4'b1111;
                    addr_d     = base_q + {21'd0, word_cnt_q, 2'b00};
                    wdata_d    = dma_data_i;
                    word_cnt_d = word_cnt_q + WordCntW'(1);
                    if (is_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            base_q     <= '0;
            last_idx_q <= '0;
            mask_q     <= '0;
            word_cnt_q <= '0;
            web_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            last_idx_q <= last_idx_d;
            mask_q     <= mask_d;
            word_cnt_q <= word_cnt_d;
            web_q      <= web_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign glb_WEB_o          = web_q;
    assign glb_addr_o         = addr_q;
    assign glb_wdata_o        = wdata_q;
    assign busy_o             = (state_q != StIdle);
    assign weight_fill_done_o = (state_q == StDone);

endmodule
